// File: rtl/vx_cache_req_arb_pkg.sv
// Shared cache-side constants and width helpers.
// Used by the request arbiter and its round-robin selector.
package vx_cache_req_arb_pkg;

  localparam int FIFO_DEPTH = 2;

  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_out_width(input int tw, input int n);
    return tw + lane_bits(n);
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin selector: first request at or after ptr wins.
// Pointer moves past the winner only when the grant is used.
module vx_rr_arbiter
  import vx_cache_req_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int LB = lane_bits(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQS-1:0] req,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output logic [LB-1:0]       grant_idx,
  output logic                grant_valid
);

  logic [LB-1:0] ptr;

  always_comb begin
    int j;
    j = 0;
    grant = '0;
    grant_idx = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx = LB'(j);
        grant[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (enable && grant_valid) begin
      if (grant_idx == LB'(NUM_REQS - 1)) ptr <= '0;
      else ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_cache_req_arb.sv
// Serializes NUM_REQS request lanes into one cache bank port.
// Round-robin grant feeds a 2-entry FIFO; lane id rides in the tag.
module vx_cache_req_arb
  import vx_cache_req_arb_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = WORD_SIZE * 8,
  localparam int LANE_BITS     = lane_bits(NUM_REQS),
  localparam int TAG_OUT_WIDTH = tag_out_width(TAG_WIDTH, NUM_REQS)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQS-1:0]                 req_in_valid,
  input  logic [NUM_REQS-1:0]                 req_in_rw,
  input  logic [NUM_REQS-1:0][WORD_SIZE-1:0]  req_in_byteen,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0] req_in_addr,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] req_in_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  req_in_tag,
  output logic [NUM_REQS-1:0]                 req_in_ready,
  output logic                                req_out_valid,
  output logic                                req_out_rw,
  output logic [WORD_SIZE-1:0]                req_out_byteen,
  output logic [ADDR_WIDTH-1:0]               req_out_addr,
  output logic [DATA_WIDTH-1:0]               req_out_data,
  output logic [TAG_OUT_WIDTH-1:0]            req_out_tag,
  input  logic                                req_out_ready
);

  localparam int PW = 1 + WORD_SIZE + ADDR_WIDTH
                    + DATA_WIDTH + TAG_OUT_WIDTH;

  logic [NUM_REQS-1:0]  grant;
  logic [LANE_BITS-1:0] grant_idx;
  logic                 grant_valid;
  logic [1:0]           count;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic                 push;
  logic                 pop;
  logic                 can_accept;
  logic                 en;
  logic [PW-1:0]        push_payload;
  logic [PW-1:0]        head;
  logic [PW-1:0]        mem [FIFO_DEPTH];

  // a full FIFO still accepts when the head leaves this cycle
  assign pop = req_out_valid & req_out_ready;
  assign can_accept = (count < 2'(FIFO_DEPTH)) | pop;
  assign en = can_accept & reset_n;
  assign push = grant_valid & en;
  assign req_in_ready = grant & {NUM_REQS{en}};

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req_in_valid),
    .enable      (en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign push_payload = {
    req_in_rw[grant_idx],
    req_in_byteen[grant_idx],
    req_in_addr[grant_idx],
    req_in_data[grant_idx],
    grant_idx,
    req_in_tag[grant_idx]
  };

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_payload;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop) count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  assign head = mem[rd_ptr];
  assign req_out_valid = (count != 2'd0);
  assign {req_out_rw, req_out_byteen, req_out_addr,
          req_out_data, req_out_tag} = head;

endmodule

// File: doc/vx_cache_req_arb.md
VX_CACHE_REQ_ARB -- requirements
Module: VX_cache_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of independent input request lanes.
REQ-002 SHALL have parameter WORD_SIZE, default 4: bytes per word; byteen width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8: per-lane input tag width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 30: word address width.
REQ-005 SHALL have parameter DATA_WIDTH, default WORD_SIZE*8: data width.
REQ-006 SHALL have derived localparam LANE_BITS = max(1, clog2(NUM_REQS)) and TAG_OUT_WIDTH = TAG_WIDTH + LANE_BITS.
REQ-007 SHALL have port clk, input, 1: the single clock; one clock, all state on its rising edge.
REQ-008 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have ports req_in_valid/rw/byteen/addr/data/tag, input, NUM_REQS lanes each (1/1/WORD_SIZE/ADDR_WIDTH/DATA_WIDTH/TAG_WIDTH bits per lane): upstream request bundle.
REQ-010 SHALL have port req_in_ready, output, NUM_REQS: per-lane accept.
REQ-011 SHALL have ports req_out_valid/rw/byteen/addr/data/tag, output, 1/1/WORD_SIZE/ADDR_WIDTH/DATA_WIDTH/TAG_OUT_WIDTH: single serialized request to cache bank.
REQ-012 SHALL have port req_out_ready, input, 1: downstream accept.

Function
REQ-013 SHALL accept at most one input lane per cycle; a transfer on lane i occurs when req_in_valid[i] & req_in_ready[i].
REQ-014 SHALL select the granted lane round-robin: the first valid lane at or after priority pointer ptr, wrapping NUM_REQS-1 -> 0.
REQ-015 SHALL drive req_in_ready[i] = 1 only for the granted lane and only when the buffer can accept; req_in_ready SHALL NOT depend on req_in_valid of other lanes beyond arbitration.
REQ-016 SHALL hold accepted requests in a 2-entry FIFO; "can accept" = count<2, or count==2 with a pop in the same cycle.
REQ-017 SHALL advance ptr to (granted lane + 1) mod NUM_REQS on an accept; ptr unchanged when no accept.
REQ-018 SHALL store req_out_tag = {lane index, input tag}, lane index in the upper LANE_BITS (0 when NUM_REQS=1).
REQ-019 SHALL drive req_out_valid = (count != 0) and req_out_* from the FIFO head, registered; latency accept->req_out_valid exactly 1 cycle.
REQ-020 SHALL pop on req_out_valid & req_out_ready; simultaneous push and pop leaves count unchanged and preserves order.
REQ-021 SHALL hold req_out_* stable while req_out_valid & !req_out_ready.
REQ-022 SHALL sustain one request per cycle when req_out_ready is held high.

Reset
REQ-023 SHALL on reset_n low asynchronously clear count to 0, ptr to 0, read/write pointers to 0; req_out_valid=0, req_in_ready=0 while reset_n is low.
REQ-024 SHALL discard FIFO contents on reset mid-operation; req_out payload outputs don't-care while req_out_valid=0.
REQ-025 SHALL resume arbitration from lane 0 on the first edge after reset_n deasserts.

Structure
REQ-026 SHALL place LANE_BITS/TAG_OUT_WIDTH helper functions in the shared cache define package, not locally.
REQ-027 SHALL implement the round-robin selector as sub-module VX_rr_arbiter (NUM_REQS requests, one-hot grant, index output, enable-gated pointer update).
REQ-028 SHALL pack request fields into one payload vector for the FIFO storage.

Verification (NUM_REQS=4, TAG_WIDTH=8)
REQ-029 Single lane: lane 2 valid, tag 0x5A, out_ready=1 -> next cycle out_valid=1, out_tag=0x25A, in_ready[2] high one cycle.
REQ-030 Fairness: all 4 lanes valid continuously, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one per cycle.
REQ-031 Backpressure: out_ready=0, lanes 0,1 valid -> two accepts then in_ready all 0; out payload stable; raise out_ready -> lane0 then lane1 requests emitted in order.
REQ-032 Full+pop: count=2, out_ready=1, lane 3 valid -> lane 3 accepted same cycle, count stays 2.
REQ-033 Reset mid-stream: count=2, assert reset_n low asynchronously between edges -> out_valid=0 immediately; after release first grant is lowest valid lane >= 0.
REQ-034 Wrap: ptr=3, only lanes 1 and 3 valid -> lane 3 granted, then lane 1.
